// File: rtl/sync_fifo_v2_if.sv
// sync_fifo_v2_if: handshake, data and status bundle of sync_fifo_v2.
interface sync_fifo_v2_if #(
   parameter int DWIDTH = 64,
   parameter int DEPTH  = 64
);
   localparam int LW = $clog2(DEPTH) + 1;
   logic              clr;
   logic              wr_en;
   logic [DWIDTH-1:0] din;
   logic              rd_en;
   logic [DWIDTH-1:0] dout;
   logic              dout_valid;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic              almost_empty;
   logic [LW-1:0]     level;
   logic [LW-1:0]     space;
   logic              overflow;
   logic              underflow;
   modport master (
      output clr, wr_en, din, rd_en,
      input  dout, dout_valid, empty, full, almost_full, almost_empty, level, space, overflow, underflow
   );
   modport slave (
      input  clr, wr_en, din, rd_en,
      output dout, dout_valid, empty, full, almost_full, almost_empty, level, space, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: synchronous FIFO with extra-bit pointers, standard/FWFT read, level/space counts,
// programmable almost flags, sticky overflow/underflow and synchronous flush.
module sync_fifo_v2 #(
   parameter int DEPTH     = 64,
   parameter int DWIDTH    = 64,
   parameter int FWFT      = 0,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input logic           clk,
   input logic           rstn,
   sync_fifo_v2_if.slave f
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
   localparam logic [PW-1:0] AF_L    = PW'(AFULL_TH);
   localparam logic [PW-1:0] AE_L    = PW'(AEMPTY_TH);
   logic [DWIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]     wptr, rptr, level;
   logic              wr_ok, rd_ok, ovf, unf;
   // acceptance looks only at registered pointer state, never at the other request
   always_comb begin
      level          = wptr - rptr;
      f.level        = level;
      f.space        = DEPTH_L - level;
      f.empty        = level == '0;
      f.full         = level == DEPTH_L;
      f.almost_full  = level >= AF_L;
      f.almost_empty = level <= AE_L;
      f.overflow     = ovf;
      f.underflow    = unf;
      wr_ok          = rstn && !f.clr && f.wr_en && !f.full;
      rd_ok          = rstn && !f.clr && f.rd_en && !f.empty;
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr <= '0;
         rptr <= '0;
         ovf  <= 1'b0;
         unf  <= 1'b0;
      end else if (f.clr) begin
         wptr <= '0;
         rptr <= '0;
         ovf  <= 1'b0;
         unf  <= 1'b0;
      end else begin
         wptr <= wptr + {{AW{1'b0}}, wr_ok};
         rptr <= rptr + {{AW{1'b0}}, rd_ok};
         ovf  <= ovf | (f.wr_en & f.full);
         unf  <= unf | (f.rd_en & f.empty);
      end
   end
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr[AW-1:0]] <= f.din;
   end
   generate
      if (FWFT != 0) begin : g_fwft
         assign f.dout       = mem[rptr[AW-1:0]];
         assign f.dout_valid = !f.empty;
      end else begin : g_std
         logic [DWIDTH-1:0] dout_q;
         logic              dv_q;
         always_ff @(posedge clk) begin
            if (!rstn) begin
               dout_q <= '0;
               dv_q   <= 1'b0;
            end else begin
               dv_q <= rd_ok;
               if (rd_ok) dout_q <= mem[rptr[AW-1:0]];
            end
         end
         assign f.dout       = dout_q;
         assign f.dout_valid = dv_q;
      end
   endgenerate
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: randomized and directed checks of sync_fifo_v2 (standard and FWFT) against a queue model.
module tb_sync_fifo_v2;
   localparam int D = 8;
   localparam int W = 16;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;
   sync_fifo_v2_if #(.DWIDTH(W), .DEPTH(D)) f0 ();
   sync_fifo_v2_if #(.DWIDTH(W), .DEPTH(D)) f1 ();
   sync_fifo_v2 #(.DEPTH(D), .DWIDTH(W), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) u0 (
      .clk(clk), .rstn(rstn), .f(f0)
   );
   sync_fifo_v2 #(.DEPTH(D), .DWIDTH(W), .FWFT(1)) u1 (
      .clk(clk), .rstn(rstn), .f(f1)
   );
   int vec = 0;
   int err = 0;
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   logic [W-1:0] dout0;
   bit dv0, ovf0, unf0, ovf1, unf1;
   task automatic idle_inputs();
      f0.wr_en = 0; f0.rd_en = 0; f0.clr = 0; f0.din = '0;
      f1.wr_en = 0; f1.rd_en = 0; f1.clr = 0; f1.din = '0;
   endtask
   task automatic do_reset();
      idle_inputs();
      rstn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      q0.delete(); q1.delete();
      dout0 = '0; dv0 = 0; ovf0 = 0; unf0 = 0; ovf1 = 0; unf1 = 0;
   endtask
   // standard-mode FIFO: one clock edge plus the queue model of what that edge does
   task automatic step0(input bit w, input bit r, input bit c, input logic [W-1:0] d);
      bit was_empty, was_full;
      f0.wr_en = w; f0.rd_en = r; f0.clr = c; f0.din = d;
      @(posedge clk);
      #1;
      idle_inputs();
      was_empty = q0.size() == 0;
      was_full  = q0.size() == D;
      if (c) begin
         q0.delete(); ovf0 = 0; unf0 = 0; dv0 = 0;
      end else begin
         dv0 = r && !was_empty;
         if (dv0) dout0 = q0.pop_front();
         if (r && was_empty) unf0 = 1;
         if (w && !was_full) q0.push_back(d);
         if (w && was_full) ovf0 = 1;
      end
   endtask
   task automatic step1(input bit w, input bit r, input bit c, input logic [W-1:0] d);
      bit was_empty, was_full;
      f1.wr_en = w; f1.rd_en = r; f1.clr = c; f1.din = d;
      @(posedge clk);
      #1;
      idle_inputs();
      was_empty = q1.size() == 0;
      was_full  = q1.size() == D;
      if (c) begin
         q1.delete(); ovf1 = 0; unf1 = 0;
      end else begin
         if (r && !was_empty) void'(q1.pop_front());
         if (r && was_empty) unf1 = 1;
         if (w && !was_full) q1.push_back(d);
         if (w && was_full) ovf1 = 1;
      end
   endtask
   task automatic test_reset();
      do_reset();
      vec++; if (f0.dout !== 16'h0) begin err++; $display("FAIL reset_dout got %h exp 0000", f0.dout); end
      vec++; if (f0.dout_valid !== 1'b0) begin err++; $display("FAIL reset_dv got %b exp 0", f0.dout_valid); end
      vec++; if (f0.empty !== 1'b1) begin err++; $display("FAIL reset_empty got %b exp 1", f0.empty); end
      vec++; if (f0.full !== 1'b0) begin err++; $display("FAIL reset_full got %b exp 0", f0.full); end
      vec++; if (f0.level !== 4'd0) begin err++; $display("FAIL reset_level got %0d exp 0", f0.level); end
      vec++; if (f0.space !== 4'd8) begin err++; $display("FAIL reset_space got %0d exp 8", f0.space); end
      vec++; if (f0.almost_empty !== 1'b1) begin err++; $display("FAIL reset_aempty got %b exp 1", f0.almost_empty); end
      vec++; if (f0.almost_full !== 1'b0) begin err++; $display("FAIL reset_afull got %b exp 0", f0.almost_full); end
      vec++; if (f0.overflow !== 1'b0 || f0.underflow !== 1'b0) begin
         err++; $display("FAIL reset_err_flags got ovf=%b unf=%b exp 0 0", f0.overflow, f0.underflow);
      end
      vec++; if (f1.dout_valid !== 1'b0 || f1.empty !== 1'b1 || f1.space !== 4'd8) begin
         err++; $display("FAIL reset_fwft got dv=%b empty=%b space=%0d exp 0 1 8", f1.dout_valid, f1.empty, f1.space);
      end
   endtask
   task automatic test_fill_drain();
      for (int i = 1; i <= D; i++) begin
         step0(1, 0, 0, W'(i));
         vec++; if (f0.level !== 4'(i)) begin err++; $display("FAIL fill_level got %0d exp %0d", f0.level, i); end
         vec++; if (f0.almost_empty !== (i <= 2)) begin err++; $display("FAIL fill_aempty lvl %0d got %b exp %b", i, f0.almost_empty, i <= 2); end
         vec++; if (f0.almost_full !== (i >= 6)) begin err++; $display("FAIL fill_afull lvl %0d got %b exp %b", i, f0.almost_full, i >= 6); end
      end
      vec++; if (f0.full !== 1'b1 || f0.space !== 4'd0) begin
         err++; $display("FAIL full_state got full=%b space=%0d exp 1 0", f0.full, f0.space);
      end
      step0(1, 0, 0, 16'h0009);
      vec++; if (f0.overflow !== 1'b1 || f0.level !== 4'd8) begin
         err++; $display("FAIL overflow got ovf=%b level=%0d exp 1 8", f0.overflow, f0.level);
      end
      for (int i = 1; i <= D; i++) begin
         step0(0, 1, 0, '0);
         vec++; if (f0.dout !== W'(i) || f0.dout_valid !== 1'b1) begin
            err++; $display("FAIL drain_dout got %h dv=%b exp %h 1", f0.dout, f0.dout_valid, W'(i));
         end
      end
      step0(0, 0, 0, '0);
      vec++; if (f0.dout_valid !== 1'b0 || f0.empty !== 1'b1 || f0.dout !== 16'h0008) begin
         err++; $display("FAIL drain_end got dv=%b empty=%b dout=%h exp 0 1 0008", f0.dout_valid, f0.empty, f0.dout);
      end
   endtask
   task automatic test_rd_wr_empty();
      step0(0, 0, 1, '0);
      step0(1, 1, 0, 16'hABCD);
      vec++; if (f0.underflow !== 1'b1 || f0.level !== 4'd1 || f0.dout_valid !== 1'b0) begin
         err++; $display("FAIL rw_empty got unf=%b level=%0d dv=%b exp 1 1 0", f0.underflow, f0.level, f0.dout_valid);
      end
      step0(0, 1, 0, '0);
      vec++; if (f0.dout !== 16'hABCD || f0.dout_valid !== 1'b1) begin
         err++; $display("FAIL rw_empty_read got %h dv=%b exp abcd 1", f0.dout, f0.dout_valid);
      end
   endtask
   task automatic test_wrap();
      step0(0, 0, 1, '0);
      for (int i = 0; i < 3; i++) step0(1, 0, 0, W'($urandom));
      for (int i = 0; i < 20; i++) begin
         step0(1, 1, 0, W'($urandom));
         vec++; if (f0.level !== 4'd3) begin err++; $display("FAIL wrap_level got %0d exp 3", f0.level); end
         vec++; if (f0.dout !== dout0 || f0.dout_valid !== 1'b1) begin
            err++; $display("FAIL wrap_dout got %h dv=%b exp %h 1", f0.dout, f0.dout_valid, dout0);
         end
      end
   endtask
   task automatic test_clr();
      step0(0, 0, 1, '0);
      for (int i = 0; i < D; i++) step0(1, 0, 0, W'(16'h100 + i));
      step0(1, 0, 0, 16'hDEAD);
      for (int i = 0; i < 3; i++) step0(0, 1, 0, '0);
      vec++; if (f0.level !== 4'd5 || f0.overflow !== 1'b1) begin
         err++; $display("FAIL clr_pre got level=%0d ovf=%b exp 5 1", f0.level, f0.overflow);
      end
      step0(1, 1, 1, 16'hBEEF);
      vec++; if (f0.level !== 4'd0 || f0.empty !== 1'b1 || f0.overflow !== 1'b0) begin
         err++; $display("FAIL clr_post got level=%0d empty=%b ovf=%b exp 0 1 0", f0.level, f0.empty, f0.overflow);
      end
      vec++; if (f0.dout_valid !== 1'b0 || f0.dout !== 16'h0102) begin
         err++; $display("FAIL clr_dout got dv=%b dout=%h exp 0 0102", f0.dout_valid, f0.dout);
      end
   endtask
   task automatic test_fwft();
      step1(0, 0, 1, '0);
      step1(1, 0, 0, 16'h1234);
      vec++; if (f1.dout !== 16'h1234 || f1.dout_valid !== 1'b1) begin
         err++; $display("FAIL fwft_head got %h dv=%b exp 1234 1", f1.dout, f1.dout_valid);
      end
      step1(0, 0, 0, '0);
      vec++; if (f1.dout !== 16'h1234 || f1.dout_valid !== 1'b1) begin
         err++; $display("FAIL fwft_hold got %h dv=%b exp 1234 1", f1.dout, f1.dout_valid);
      end
      step1(0, 1, 0, '0);
      vec++; if (f1.empty !== 1'b1 || f1.dout_valid !== 1'b0) begin
         err++; $display("FAIL fwft_pop got empty=%b dv=%b exp 1 0", f1.empty, f1.dout_valid);
      end
   endtask
   task automatic test_random();
      bit w, r, c;
      for (int i = 0; i < 400; i++) begin
         w = $urandom_range(0, 9) < 6;
         r = $urandom_range(0, 9) < 5;
         c = $urandom_range(0, 59) == 0;
         step0(w, r, c, W'($urandom));
         vec++; if (f0.level !== 4'(q0.size()) || f0.space !== 4'(D - q0.size())) begin
            err++; $display("FAIL rnd0_count got level=%0d space=%0d exp %0d %0d", f0.level, f0.space, q0.size(), D - q0.size());
         end
         vec++; if (f0.empty !== (q0.size() == 0) || f0.full !== (q0.size() == D)) begin
            err++; $display("FAIL rnd0_ef got empty=%b full=%b exp level %0d", f0.empty, f0.full, q0.size());
         end
         vec++; if (f0.almost_full !== (q0.size() >= 6) || f0.almost_empty !== (q0.size() <= 2)) begin
            err++; $display("FAIL rnd0_almost got af=%b ae=%b exp level %0d", f0.almost_full, f0.almost_empty, q0.size());
         end
         vec++; if (f0.dout !== dout0 || f0.dout_valid !== dv0) begin
            err++; $display("FAIL rnd0_dout got %h dv=%b exp %h %b", f0.dout, f0.dout_valid, dout0, dv0);
         end
         vec++; if (f0.overflow !== ovf0 || f0.underflow !== unf0) begin
            err++; $display("FAIL rnd0_sticky got ovf=%b unf=%b exp %b %b", f0.overflow, f0.underflow, ovf0, unf0);
         end
      end
      step0(0, 1, 0, '0);
      do_reset();
      vec++; if (f0.dout_valid !== 1'b0 || f0.dout !== 16'h0 || f0.level !== 4'd0) begin
         err++; $display("FAIL mid_reset got dv=%b dout=%h level=%0d exp 0 0000 0", f0.dout_valid, f0.dout, f0.level);
      end
      for (int i = 0; i < 400; i++) begin
         w = $urandom_range(0, 9) < 6;
         r = $urandom_range(0, 9) < 5;
         c = $urandom_range(0, 59) == 0;
         step1(w, r, c, W'($urandom));
         vec++; if (f1.level !== 4'(q1.size()) || f1.dout_valid !== (q1.size() != 0)) begin
            err++; $display("FAIL rnd1_level got level=%0d dv=%b exp %0d %b", f1.level, f1.dout_valid, q1.size(), q1.size() != 0);
         end
         if (q1.size() != 0) begin
            vec++; if (f1.dout !== q1[0]) begin err++; $display("FAIL rnd1_head got %h exp %h", f1.dout, q1[0]); end
         end
         vec++; if (f1.overflow !== ovf1 || f1.underflow !== unf1) begin
            err++; $display("FAIL rnd1_sticky got ovf=%b unf=%b exp %b %b", f1.overflow, f1.underflow, ovf1, unf1);
         end
      end
   endtask
   initial begin
      idle_inputs();
      test_reset();
      test_fill_drain();
      test_rd_wr_empty();
      test_wrap();
      test_clr();
      test_fwft();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule

// File: doc/sync_fifo_v2.md
# sync_fifo_v2

Parametrised synchronous FIFO: successor to the team's basic FIFO, used between the PicoRV32 interface and the crypto cores. It exposes all DEPTH entries (extra-bit pointers), selectable standard or first-word-fall-through (FWFT) read mode, and exact occupancy/free-space counts. It also provides programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. Single clock domain.

## Interface
- DEPTH, 64: number of entries; power of 2, ≥ 2.
- DWIDTH, 64: data width in bits.
- FWFT, 0: 0 = standard (registered dout after read); 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2: almost_full asserted when level ≥ AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserted when level ≤ AEMPTY_TH.
- Reset rstn, synchronous, active-low; clock clk.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous active-low reset.
- clr  in  1  synchronous flush, lower priority than rstn.
- wr_en  in  1  write request.
- din  in  DWIDTH  write data.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge head word).
- dout  out  DWIDTH  read data.
- dout_valid  out  1  FWFT=0: one-cycle pulse, dout updated; FWFT=1: equals !empty.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- almost_full  out  1  level ≥ AFULL_TH.
- almost_empty  out  1  level ≤ AEMPTY_TH.
- level  out  $clog2(DEPTH)+1  stored words, 0..DEPTH.
- space  out  $clog2(DEPTH)+1  DEPTH − level.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Pointers wptr/rptr are $clog2(DEPTH)+1 bits; address = low bits; level = wptr − rptr (modulo 2^(AW+1)). Wrap-around is natural binary rollover; no special case.
- Write accepted iff wr_en && !full; stores din at mem[wptr], wptr+1.
- Read accepted iff rd_en && !empty; rptr+1.
- Acceptance uses registered full/empty only (no rd_en→write-accept path).
  - Write on full is rejected even with a simultaneous accepted read.
  - Read on empty is rejected even with a simultaneous accepted write.
- Simultaneous accepted read and write: level unchanged; pointers both advance.
- Rejected write sets overflow; rejected read sets underflow. Both stay set until clr or rstn.
- FWFT=0: on accepted read, dout ← mem[rptr] and dout_valid=1 next cycle; otherwise dout holds and dout_valid=0.
- FWFT=1: dout = mem[rptr[AW-1:0]] continuously; content undefined/don't-care while empty.
- Flags and space are combinational decodes of registered level; level is registered (or derived from registered pointers).
- clr (rstn high): pointers, overflow, underflow ← 0; dout_valid ← 0; dout holds. wr_en/rd_en in the same cycle are ignored.
- Memory contents are not reset.

## Timing
- Reset values: dout=0, dout_valid=0, empty=1, full=0, level=0, space=DEPTH, almost_empty=1 (AEMPTY_TH ≥ 0), almost_full=(AFULL_TH==0), overflow=0, underflow=0.
- Write at edge N: level/empty/full reflect it after edge N. FWFT=1: word on dout in the cycle after edge N.
- FWFT=0 read latency: rd_en sampled at edge N → dout/dout_valid valid after edge N, for one cycle.
- FWFT=1: rd_en at edge N pops; next word (if any) on dout after edge N.
- Reset or clr mid-operation: takes effect at that edge; any in-flight read data is discarded (dout_valid=0 next cycle).
- Throughput: one write and one read per cycle, sustained.

## Test plan
- DEPTH=8, DWIDTH=16, FWFT=0: reset, then write 0x0001..0x0008 → full=1, level=8, space=0. A 9th write → overflow=1, level stays 8. Read 8 → dout 0x0001..0x0008, each 1 cycle after rd_en with dout_valid pulses; empty=1.
- Empty FIFO, rd_en=1 with wr_en=1 din=0xABCD → write accepted, read rejected, underflow=1, level=1. Next cycle read → dout=0xABCD.
- Wrap: 20 cycles of simultaneous write/read at level 3 → level constant 3, data order preserved across pointer rollover.
- Thresholds AFULL_TH=6, AEMPTY_TH=2: fill 0→8 → almost_empty drops at level 3, almost_full rises at level 6.
- FWFT=1: write 0x1234 → dout=0x1234, dout_valid=1 next cycle without rd_en. rd_en pops → empty=1.
- clr at level 5 with overflow set → level=0, empty=1, overflow=0 next cycle. Same-cycle wr_en ignored.
